// File: rtl/sync_to_4ph_source.sv
// Clocked valid/ready to 4-phase bundled-data bridge.
// Words from a clocked producer are buffered in a small FIFO. Each word is placed
// on Ldata, held for SETUP_CYC cycles, then offered with a return-to-zero Lreq/Lack
// handshake. Lack is synchronised into clk, and a watchdog flags a stalled handshake.
module sync_to_4ph_source #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         Lreq,
  input  logic                         Lack,
  output logic [DATA_W-1:0]            Ldata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         timeout_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int SCNT_W = $clog2(SETUP_CYC+1);
  localparam int WCNT_W = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_HI, WAIT_LO} state_t;

  state_t                    state, state_nxt;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      lack_s;
  logic [SCNT_W-1:0]         scnt, scnt_nxt;
  logic [WCNT_W-1:0]         wcnt;
  logic                      lreq_nxt;
  logic                      load;
  logic                      wcnt_clr;
  logic                      wcnt_inc;
  logic                      push;
  logic                      pop;

  // Saturating increment of the watchdog counter; it parks at TIMEOUT_CYC.
  function automatic logic [WCNT_W-1:0] wcnt_sat_inc(input logic [WCNT_W-1:0] v);
    if (v == WCNT_W'(TIMEOUT_CYC))
      return v;
    return v + 1'b1;
  endfunction

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = load;
  assign lack_s   = sync_q[SYNC_STAGES-1];

  // Lack is asynchronous: pass it through a plain flop chain before the FSM sees it.
  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], Lack};
  end

  // FIFO storage is data only and needs no reset; pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Handshake FSM state, request, setup counter and the word presented on Ldata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Lreq  <= 1'b0;
      scnt  <= '0;
      Ldata <= '0;
    end else begin
      state <= state_nxt;
      Lreq  <= lreq_nxt;
      scnt  <= scnt_nxt;
      if (load)
        Ldata <= mem[rd_ptr];
    end
  end

  // Next-state logic: load a word, let Ldata settle, then run the 4-phase cycle.
  always_comb begin
    state_nxt = state;
    lreq_nxt  = Lreq;
    scnt_nxt  = scnt;
    load      = 1'b0;
    wcnt_clr  = 1'b0;
    wcnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load      = 1'b1;
          scnt_nxt  = SCNT_W'(SETUP_CYC);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (scnt == SCNT_W'(1)) begin
          lreq_nxt  = 1'b1;
          wcnt_clr  = 1'b1;
          state_nxt = WAIT_HI;
        end else begin
          scnt_nxt  = scnt - 1'b1;
        end
      end
      WAIT_HI: begin
        if (lack_s) begin
          lreq_nxt  = 1'b0;
          wcnt_clr  = 1'b1;
          state_nxt = WAIT_LO;
        end else begin
          wcnt_inc  = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!lack_s)
          state_nxt = IDLE;
        else
          wcnt_inc  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog: the flag sets on the same edge the counter reaches TIMEOUT_CYC and
  // stays set; the handshake itself carries on and may still complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (wcnt_clr) begin
      wcnt        <= '0;
    end else if (wcnt_inc) begin
      wcnt <= wcnt_sat_inc(wcnt);
      if (wcnt == WCNT_W'(TIMEOUT_CYC-1))
        timeout_err <= 1'b1;
    end
  end

endmodule
